// File: rtl/mem_lsu.sv
// MEM stage load/store unit: drives the data bus through a req/ack handshake, stalls the pipeline while busy.
// Optional MEM_ALIGN_CHECK_EN: misaligned half/word accesses skip the bus and flag mem_misalign.
module mem_lsu #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ex_waddr,
  input  logic                  ex_reg_we,
  input  logic [DATA_W-1:0]     ex_data,
  input  logic [3:0]            ex_mem_op,
  input  logic [ADDR_W-1:0]     ex_mem_addr,
  input  logic [DATA_W-1:0]     ex_store_data,
  output logic                  dbus_req,
  output logic                  dbus_we,
  output logic [ADDR_W-1:0]     dbus_addr,
  output logic [3:0]            dbus_sel,
  output logic [DATA_W-1:0]     dbus_wdata,
  input  logic [DATA_W-1:0]     dbus_rdata,
  input  logic                  dbus_ack,
  output logic                  stall_req,
  output logic [REG_ADDR_W-1:0] mem_waddr,
  output logic                  mem_reg_we,
  output logic [DATA_W-1:0]     mem_data
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic                  mem_misalign
`endif
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state_q, state_d;
  logic              is_load, is_store, is_mem;
  logic              issue, stall_c;
  logic              misalign_c, misalign_q;
  logic [3:0]        sel_c;
  logic [DATA_W-1:0] wdata_c;
  logic [DATA_W-1:0] load_ext_c;
  logic [DATA_W-1:0] load_q;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [4:0]        byte_sh;

  assign is_load  = (ex_mem_op >= OP_LB) && (ex_mem_op <= OP_LW);
  assign is_store = (ex_mem_op >= OP_SB) && (ex_mem_op <= OP_SW);
  assign is_mem   = is_load | is_store;

`ifdef MEM_ALIGN_CHECK_EN
  always_comb begin
    misalign_c = 1'b0;
    case (ex_mem_op)
      OP_LH, OP_LHU, OP_SH: misalign_c = ex_mem_addr[0];
      OP_LW, OP_SW:         misalign_c = |ex_mem_addr[1:0];
      default:              misalign_c = 1'b0;
    endcase
  end

  // High only during the DONE cycle of a bus-skipped access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= (state_q == IDLE) && is_mem && misalign_c;
  end

  assign mem_misalign = misalign_q;
`else
  assign misalign_c = 1'b0;
  assign misalign_q = 1'b0;
`endif

  // Big-endian lane select and store replication.
  always_comb begin
    sel_c   = 4'b0000;
    wdata_c = '0;
    case (ex_mem_op)
      OP_LB, OP_LBU: sel_c = 4'b1000 >> ex_mem_addr[1:0];
      OP_LH, OP_LHU: sel_c = ex_mem_addr[1] ? 4'b0011 : 4'b1100;
      OP_LW:         sel_c = 4'b1111;
      OP_SB: begin
        sel_c   = 4'b1000 >> ex_mem_addr[1:0];
        wdata_c = {4{ex_store_data[7:0]}};
      end
      OP_SH: begin
        sel_c   = ex_mem_addr[1] ? 4'b0011 : 4'b1100;
        wdata_c = {2{ex_store_data[15:0]}};
      end
      OP_SW: begin
        sel_c   = 4'b1111;
        wdata_c = ex_store_data;
      end
      default: ;
    endcase
  end

  assign byte_sh = {~ex_mem_addr[1:0], 3'b000};
  assign rd_byte = 8'(dbus_rdata >> byte_sh);
  assign rd_half = ex_mem_addr[1] ? dbus_rdata[15:0] : dbus_rdata[31:16];

  always_comb begin
    load_ext_c = dbus_rdata;
    case (ex_mem_op)
      OP_LB:   load_ext_c = {{(DATA_W-8){rd_byte[7]}}, rd_byte};
      OP_LBU:  load_ext_c = {{(DATA_W-8){1'b0}}, rd_byte};
      OP_LH:   load_ext_c = {{(DATA_W-16){rd_half[15]}}, rd_half};
      OP_LHU:  load_ext_c = {{(DATA_W-16){1'b0}}, rd_half};
      default: load_ext_c = dbus_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    stall_c    = 1'b0;
    issue      = 1'b0;
    mem_waddr  = ex_waddr;
    mem_reg_we = ex_reg_we;
    mem_data   = ex_data;
    case (state_q)
      IDLE: begin
        if (is_mem) begin
          stall_c    = 1'b1;
          mem_reg_we = 1'b0;
          if (misalign_c) begin
            state_d = DONE;
          end else begin
            issue   = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        stall_c    = 1'b1;
        mem_reg_we = 1'b0;
        if (dbus_ack) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        if (is_load && !misalign_q) mem_data = load_q;
        else                        mem_reg_we = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // The stall is released as soon as reset is seen, matching the dropped request.
  assign stall_req = stall_c & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_sel   <= 4'b0000;
      dbus_wdata <= '0;
      load_q     <= '0;
    end else begin
      if (issue) begin
        dbus_req   <= 1'b1;
        dbus_we    <= is_store;
        dbus_addr  <= {ex_mem_addr[ADDR_W-1:2], 2'b00};
        dbus_sel   <= sel_c;
        dbus_wdata <= wdata_c;
      end else if ((state_q == REQ) && dbus_ack) begin
        dbus_req <= 1'b0;
      end
      if ((state_q == REQ) && dbus_ack && is_load) load_q <= load_ext_c;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ex_waddr;
  logic        ex_reg_we;
  logic [31:0] ex_data;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_store_data;
  logic        dbus_req, dbus_we, dbus_ack;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_sel;
  logic        stall_req, mem_reg_we;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_data;
`ifdef MEM_ALIGN_CHECK_EN
  logic        mem_misalign;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  int          r_stalls, r_reqs, r_mis;
  logic [3:0]  r_sel;
  logic [31:0] r_wdata, r_addr, r_data;
  logic        r_we, r_regwe;

  mem_lsu dut (
    .clk(clk), .rst(rst),
    .ex_waddr(ex_waddr), .ex_reg_we(ex_reg_we), .ex_data(ex_data),
    .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_sel(dbus_sel),
    .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
    .stall_req(stall_req), .mem_waddr(mem_waddr), .mem_reg_we(mem_reg_we),
    .mem_data(mem_data)
`ifdef MEM_ALIGN_CHECK_EN
    , .mem_misalign(mem_misalign)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Runs one instruction from IDLE; must be called just after a rising edge.
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                        input int waits, input logic [31:0] rdata);
    bit done = 0;
    ex_mem_op = op; ex_mem_addr = addr; ex_store_data = sdata;
    ex_reg_we = 1'b1; ex_waddr = 5'd7; ex_data = 32'h5555_AAAA;
    r_stalls = 0; r_reqs = 0; r_mis = 0;
    r_sel = 4'h0; r_wdata = 32'h0; r_addr = 32'h0; r_we = 1'b0; r_data = 32'h0; r_regwe = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
`ifdef MEM_ALIGN_CHECK_EN
      if (mem_misalign) r_mis++;
`endif
      if (dbus_req) begin
        r_reqs++;
        r_sel = dbus_sel; r_wdata = dbus_wdata; r_addr = dbus_addr; r_we = dbus_we;
        if (r_reqs == waits + 1) begin
          dbus_ack = 1'b1;
          dbus_rdata = rdata;
        end
      end
      if (stall_req) r_stalls++;
      else begin
        done = 1;
        r_data = mem_data;
        r_regwe = mem_reg_we;
      end
      @(posedge clk); #1;
      dbus_ack = 1'b0;
      dbus_rdata = 32'h0;
    end
    if (!done) check("timeout", 32'd0, 32'd1);
    ex_mem_op = 4'd0;
  endtask

  initial begin
    rst = 1'b1;
    ex_waddr = 5'd1; ex_reg_we = 1'b0; ex_data = 32'h0; ex_mem_op = 4'd0;
    ex_mem_addr = 32'h0; ex_store_data = 32'h0; dbus_rdata = 32'h0; dbus_ack = 1'b0;
    #3;
    check("rst_req", 32'(dbus_req), 32'd0);
    check("rst_stall", 32'(stall_req), 32'd0);
    check("rst_addr", dbus_addr, 32'h0);
    check("rst_sel", 32'(dbus_sel), 32'h0);
    check("rst_wdata", dbus_wdata, 32'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // ALU pass-through
    ex_mem_op = 4'd0; ex_waddr = 5'd3; ex_data = 32'h1234; ex_reg_we = 1'b1;
    #1;
    check("alu_waddr", 32'(mem_waddr), 32'd3);
    check("alu_data", mem_data, 32'h1234);
    check("alu_we", 32'(mem_reg_we), 32'd1);
    check("alu_stall", 32'(stall_req), 32'd0);
    @(posedge clk); #1;

    // ack while idle must not start anything
    dbus_ack = 1'b1;
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    check("idle_ack_req", 32'(dbus_req), 32'd0);
    check("idle_ack_stall", 32'(stall_req), 32'd0);

    run_op(4'd5, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    check("lw_sel", 32'(r_sel), 32'hF);
    check("lw_addr", r_addr, 32'h100);
    check("lw_we", 32'(r_we), 32'd0);
    check("lw_stall", 32'(r_stalls), 32'd2);
    check("lw_reqs", 32'(r_reqs), 32'd1);
    check("lw_data", r_data, 32'hDEADBEEF);
    check("lw_regwe", 32'(r_regwe), 32'd1);

    run_op(4'd1, 32'h103, 32'h0, 0, 32'h000000F0);
    check("lb_sel", 32'(r_sel), 32'h1);
    check("lb_data", r_data, 32'hFFFFFFF0);

    run_op(4'd2, 32'h103, 32'h0, 1, 32'h000000F0);
    check("lbu_data", r_data, 32'h000000F0);
    check("lbu_stall", 32'(r_stalls), 32'd3);

    run_op(4'd3, 32'h100, 32'h0, 0, 32'h8001_7777);
    check("lh_sel", 32'(r_sel), 32'hC);
    check("lh_data", r_data, 32'hFFFF8001);

    run_op(4'd4, 32'h102, 32'h0, 0, 32'h1234_8001);
    check("lhu_sel", 32'(r_sel), 32'h3);
    check("lhu_data", r_data, 32'h00008001);

    run_op(4'd7, 32'h202, 32'h0000ABCD, 3, 32'h0);
    check("sh_sel", 32'(r_sel), 32'h3);
    check("sh_wdata", r_wdata, 32'hABCDABCD);
    check("sh_addr", r_addr, 32'h200);
    check("sh_we", 32'(r_we), 32'd1);
    check("sh_stall", 32'(r_stalls), 32'd5);
    check("sh_reqs", 32'(r_reqs), 32'd4);
    check("sh_regwe", 32'(r_regwe), 32'd0);

    run_op(4'd6, 32'h101, 32'h1234_565A, 0, 32'h0);
    check("sb_sel", 32'(r_sel), 32'h4);
    check("sb_wdata", r_wdata, 32'h5A5A5A5A);

    run_op(4'd8, 32'h3FC, 32'hCAFEF00D, 0, 32'h0);
    check("sw_sel", 32'(r_sel), 32'hF);
    check("sw_wdata", r_wdata, 32'hCAFEF00D);

`ifdef MEM_ALIGN_CHECK_EN
    run_op(4'd5, 32'h101, 32'h0, 0, 32'h0);
    check("mis_reqs", 32'(r_reqs), 32'd0);
    check("mis_stall", 32'(r_stalls), 32'd1);
    check("mis_pulse", 32'(r_mis), 32'd1);
    check("mis_regwe", 32'(r_regwe), 32'd0);
    #1;
    check("mis_clear", 32'(mem_misalign), 32'd0);
`else
    run_op(4'd5, 32'h101, 32'h0, 0, 32'h0BADF00D);
    check("lw_mis_addr", r_addr, 32'h100);
    check("lw_mis_data", r_data, 32'h0BADF00D);
`endif

    // reset while a request is pending
    ex_mem_op = 4'd5; ex_mem_addr = 32'h300; ex_reg_we = 1'b1;
    @(posedge clk); #1;
    check("rreq_pre", 32'(dbus_req), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rreq_req", 32'(dbus_req), 32'd0);
    check("rreq_stall", 32'(stall_req), 32'd0);
    ex_mem_op = 4'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(4'd5, 32'h104, 32'h0, 1, 32'h11223344);
    check("post_rst_data", r_data, 32'h11223344);
    check("post_rst_stall", 32'(r_stalls), 32'd3);
    check("post_rst_regwe", 32'(r_regwe), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
